// File: rtl/apb3_master.sv
// APB3 initiator: turns a single-outstanding command/response handshake into
// APB3 SETUP/ACCESS transfers, with an optional PREADY timeout.
module apb3_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH*8-1:0]   cmd_wdata,
  output logic                     rsp_valid,
  output logic [BUS_WIDTH*8-1:0]   rsp_rdata,
  output logic                     rsp_error,
  output logic                     rsp_timeout,
  output logic [ADDRESS_WIDTH-1:0] m_apb_paddr,
  output logic                     m_apb_psel,
  output logic                     m_apb_penable,
  input  logic                     m_apb_pready,
  output logic                     m_apb_pwrite,
  output logic [BUS_WIDTH*8-1:0]   m_apb_pwdata,
  input  logic [BUS_WIDTH*8-1:0]   m_apb_prdata,
  input  logic                     m_apb_pslverror
);

  localparam int DW = BUS_WIDTH * 8;
  // A disabled timeout still keeps a 1-bit counter so no zero-width vector appears
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               psel_r, psel_s;
  logic               penable_r, penable_s;
  logic               pwrite_r, pwrite_s;
  logic [ADDRESS_WIDTH-1:0] paddr_r, paddr_s;
  logic [DW-1:0]      pwdata_r, pwdata_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [DW-1:0]      rsp_rdata_r, rsp_rdata_s;
  logic               rsp_error_r, rsp_error_s;
  logic               rsp_timeout_r, rsp_timeout_s;
  logic               cmd_ready_s;

  assign cmd_ready_s   = (state_r == ST_IDLE) && !rst;
  assign cmd_ready     = cmd_ready_s;
  assign m_apb_psel    = psel_r;
  assign m_apb_penable = penable_r;
  assign m_apb_pwrite  = pwrite_r;
  assign m_apb_paddr   = paddr_r;
  assign m_apb_pwdata  = pwdata_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_error     = rsp_error_r;
  assign rsp_timeout   = rsp_timeout_r;

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    pwrite_s      = pwrite_r;
    paddr_s       = paddr_r;
    pwdata_s      = pwdata_r;
    rsp_valid_s   = 1'b0;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_error_s   = rsp_error_r;
    rsp_timeout_s = rsp_timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_s) begin
          paddr_s   = cmd_addr;
          pwrite_s  = cmd_write;
          pwdata_s  = cmd_write ? cmd_wdata : {DW{1'b0}};
          psel_s    = 1'b1;
          penable_s = 1'b0;
          state_s   = ST_SETUP;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_s = 1'b1;
        cnt_s     = {CW{1'b0}};
        state_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_apb_pready) begin
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          state_s       = ST_IDLE;
          rsp_valid_s   = 1'b1;
          rsp_error_s   = m_apb_pslverror;
          rsp_timeout_s = 1'b0;
          rsp_rdata_s   = pwrite_r ? {DW{1'b0}} : m_apb_prdata;
        end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          state_s       = ST_IDLE;
          rsp_valid_s   = 1'b1;
          rsp_error_s   = 1'b1;
          rsp_timeout_s = 1'b1;
          rsp_rdata_s   = {DW{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        psel_s    = 1'b0;
        penable_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDRESS_WIDTH{1'b0}};
      pwdata_r      <= {DW{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DW{1'b0}};
      rsp_error_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      pwrite_r      <= pwrite_s;
      paddr_r       <= paddr_s;
      pwdata_r      <= pwdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_error_r   <= rsp_error_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

endmodule

// File: doc/apb3_master.md
Name: apb3_master

Overview:
- APB3 initiator (requester) that turns a single-outstanding command/response interface into APB3 SETUP/ACCESS transfers.
- Sits between a local controller (test sequencer, boot loader, debug bridge) and APB3 slaves such as the ROM and register blocks on the peripheral bus.
- Adds a programmable PREADY timeout so that a hung slave cannot lock up the initiator.

Parameters:
- ADDRESS_WIDTH, 16: width of cmd_addr and m_apb_paddr.
- BUS_WIDTH, 4: data bus width in bytes; data ports are BUS_WIDTH*8 bits.
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles to wait for PREADY. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  transfer address.
- cmd_wdata  in  BUS_WIDTH*8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  BUS_WIDTH*8  read data.
- rsp_error  out  1  slave error or timeout.
- rsp_timeout  out  1  completion was caused by timeout.
- m_apb_paddr  out  ADDRESS_WIDTH  APB address.
- m_apb_psel  out  1  APB select (single slave select).
- m_apb_penable  out  1  APB enable.
- m_apb_pready  in  1  slave ready.
- m_apb_pwrite  out  1  APB direction.
- m_apb_pwdata  out  BUS_WIDTH*8  APB write data.
- m_apb_prdata  in  BUS_WIDTH*8  APB read data.
- m_apb_pslverror  in  1  slave error, valid only with pready.

Behaviour:
- State machine: IDLE, SETUP, ACCESS. All APB and rsp outputs are registered.
- Reset values: state IDLE; psel, penable, pwrite, paddr, pwdata = 0; rsp_valid, rsp_rdata, rsp_error, rsp_timeout = 0; timeout counter = 0.
- cmd_ready = 1 only when state is IDLE and rst is low (combinational).
- IDLE: when cmd_valid and cmd_ready are high at an edge:
  - latch paddr = cmd_addr and pwrite = cmd_write;
  - latch pwdata = cmd_wdata for writes, 0 for reads;
  - psel <= 1, penable stays 0, go to SETUP.
- SETUP: exactly one cycle. penable <= 1, counter cleared, go to ACCESS.
- ACCESS: psel = 1 and penable = 1; paddr, pwrite and pwdata are held stable.
  - pready = 1 at an edge:
    - psel <= 0, penable <= 0, go to IDLE;
    - rsp_valid <= 1 for one cycle;
    - rsp_error <= pslverror, rsp_timeout <= 0;
    - rsp_rdata <= prdata for reads, 0 for writes.
  - pready = 0 and TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
    - abort: psel <= 0, penable <= 0, go to IDLE;
    - rsp_valid <= 1, rsp_error <= 1, rsp_timeout <= 1, rsp_rdata <= 0.
  - Otherwise the counter increments. Counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps.
- pslverror is ignored while pready = 0.
- rsp_valid is 1 in the first IDLE cycle after completion, which is also a cycle with cmd_ready = 1.
  - A new command may be accepted in that same cycle: back-to-back issue.
- rsp_rdata, rsp_error and rsp_timeout hold their values until the next completion.
- Latency:
  - acceptance edge T; SETUP in cycle T+1; ACCESS from T+2.
  - With zero wait states, rsp_valid is high in cycle T+3.
  - Minimum command-to-command spacing is 3 cycles.
- paddr and pwrite keep their last values in IDLE; pwdata also keeps its last value in IDLE.
- Reset asserted mid-transfer: on the next edge psel and penable drop to 0 and the state returns to IDLE. No rsp_valid is produced for the aborted command.
- cmd_valid asserted while not in IDLE: ignored. The source holds the command until it sees cmd_ready.

Test Plan:
- Zero-wait read: cmd addr 0x0010, read; slave returns pready = 1 in the first ACCESS cycle with prdata 0x41424344. Expect psel at T+1, penable at T+2, rsp_valid at T+3, rsp_rdata = 0x41424344, rsp_error = 0.
- Wait-state write: addr 0x0004, wdata 0xDEADBEEF; pready held low for 3 ACCESS cycles. Expect paddr and pwdata stable throughout, penable high for 4 cycles, rsp_valid once, rsp_rdata = 0.
- Slave error: read with pslverror = 1 together with pready. Expect rsp_error = 1, rsp_timeout = 0. Also pulse pslverror while pready = 0 earlier in the same transfer and check it is ignored.
- Timeout: TIMEOUT_CYCLES = 8, pready tied low. Expect penable high for exactly 8 cycles, then psel = 0, rsp_valid = 1, rsp_error = 1, rsp_timeout = 1, rsp_rdata = 0.
- Back-to-back: cmd_valid held high with 4 queued commands and zero-wait slave. Expect new acceptances every 3 cycles, each rsp_valid coinciding with the next acceptance, and 4 responses in order.
- Reset mid-ACCESS: assert rst for 1 cycle during a wait-stated read. Expect psel = 0 and penable = 0 after the edge, no rsp_valid, and cmd_ready = 1 once rst is low.
